fmi_tile_loader: RTL and testbench

Write-side controller for the FM-input tile RAM. It accepts a start command with the tile dimensions, then consumes a valid/ready pixel stream from the external-memory fetch path and produces the RAM write port signals (address, data, write strobe). Addresses are linear and contiguous; the block signals completion so the convolution controller can start reading the tile.

---
 rtl/irb_pkg.sv | 20 ++
 rtl/fmi_scan_cnt.sv | 96 +++++++++
 rtl/fmi_tile_loader.sv | 191 +++++++++++++++++++
 tb/tb_fmi_tile_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irb_pkg.sv
// Shared definitions for the input-RAM-buffer (IRB) blocks.
//
// Supplies the pixel width and the FM-input tile RAM depth used by the
// tile loader, the loader state encoding, and the RAM address width.
// The loader's optional zero-border mode is selected by the
// FMI_ZERO_PAD_EN macro in the files that use this package.

package irb_pkg;

  localparam int PX_W       = 8;
  localparam int FMI_N_ELEM = 1024;
  localparam int FMI_ADDR_W = $clog2(FMI_N_ELEM + 1);

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } fmi_ld_state_t;

endpackage

// File: rtl/fmi_scan_cnt.sv
// Nested row/column/channel scan counter for the FM-input tile loader.
//
// Scan order is channel fastest, then column, then row. The limits are the
// (possibly padded) plane dimensions and are assumed non-zero whenever the
// counter is advanced.
//
// Configuration: FMI_ZERO_PAD_EN enables the pad-position flag (outermost
// row/column of every plane). Without it isPad_o is always 0.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   clear_i        return all counters to 0 (takes priority over adv_i)
//   adv_i          step to the next scan position
//   rowLim_i       number of rows
//   colLim_i       number of columns
//   chLim_i        number of channels
//   row_o, col_o, ch_o  current position
//   isPad_o        current position lies on the zero border
//   isLast_o       current position is the final one of the tile

module fmi_scan_cnt #(
  parameter int CW = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          adv_i,
  input  logic [CW-1:0] rowLim_i,
  input  logic [CW-1:0] colLim_i,
  input  logic [CW-1:0] chLim_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] ch_o,
  output logic          isPad_o,
  output logic          isLast_o
);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] ch_q,  ch_d;
  logic          rowEnd, colEnd, chEnd;

  assign rowEnd = (row_q == rowLim_i - CW'(1));
  assign colEnd = (col_q == colLim_i - CW'(1));
  assign chEnd  = (ch_q  == chLim_i  - CW'(1));

  // Ripple-carry style nested counting: channel wraps into column,
  // column wraps into row. The row is never wrapped because the loader
  // stops advancing after the last position.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ch_d  = ch_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
      ch_d  = '0;
    end else if (adv_i) begin
      if (chEnd) begin
        ch_d = '0;
        if (colEnd) begin
          col_d = '0;
          row_d = row_q + CW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end else begin
        ch_d = ch_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
      ch_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      ch_q  <= ch_d;
    end
  end

  assign row_o    = row_q;
  assign col_o    = col_q;
  assign ch_o     = ch_q;
  assign isLast_o = rowEnd && colEnd && chEnd;

`ifdef FMI_ZERO_PAD_EN
  assign isPad_o = (row_q == '0) || rowEnd || (col_q == '0) || colEnd;
`else
  assign isPad_o = 1'b0;
`endif

endmodule

// File: rtl/fmi_tile_loader.sv
// Write-side controller for the FM-input tile RAM.
//
// Takes a start command with tile dimensions, consumes a valid/ready pixel
// stream and produces registered RAM write signals at linear, contiguous
// addresses starting at 0. Signals completion with a one-cycle done pulse
// and rejects impossible tiles with a one-cycle err pulse.
//
// Configuration: FMI_ZERO_PAD_EN inserts a 1-pixel zero border around every
// channel plane; only the interior positions consume stream beats.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   start_i               load command, sampled only when idle
//   tile_h_i/w_i/c_i      unpadded rows, columns, channels (sampled with start)
//   s_data_i, s_valid_i   input pixel stream
//   s_ready_o             stream beat accepted this cycle (combinational)
//   ram_addr_o/data_o     registered RAM write address and data
//   ram_write_o           registered RAM write strobe
//   busy_o                load in progress
//   done_o                one-cycle pulse after the final write
//   err_o                 one-cycle pulse after a rejected start

module fmi_tile_loader
  import irb_pkg::*;
#(
  parameter int DIM_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      tile_h_i,
  input  logic [DIM_W-1:0]      tile_w_i,
  input  logic [DIM_W-1:0]      tile_c_i,
  input  logic [PX_W-1:0]       s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [FMI_ADDR_W-1:0] ram_addr_o,
  output logic [PX_W-1:0]       ram_data_o,
  output logic                  ram_write_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // One extra bit per dimension holds the padded size (up to 2^DIM_W+1).
  localparam int CW = DIM_W + 1;
  // The product of three CW-bit factors never overflows 3*CW bits.
  localparam int PW = 3 * CW;

  fmi_ld_state_t         state_q, state_d;
  logic [CW-1:0]         hLim_q, hLim_d;
  logic [CW-1:0]         wLim_q, wLim_d;
  logic [CW-1:0]         cLim_q, cLim_d;
  logic [FMI_ADDR_W-1:0] addrCnt_q, addrCnt_d;
  logic [FMI_ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic [PX_W-1:0]       ramData_q, ramData_d;
  logic                  ramWrite_q, ramWrite_d;
  logic                  err_q, err_d;
  logic                  fin_q, fin_d;

  logic [CW-1:0] hEff, wEff, cEff;
  logic [PW-1:0] tileTotal;
  logic          dimZero, tooBig;
  logic          scanClear, scanAdv, isPad, isLast, step;
  logic [CW-1:0] scanRow, scanCol, scanCh;

`ifdef FMI_ZERO_PAD_EN
  assign hEff = {1'b0, tile_h_i} + CW'(2);
  assign wEff = {1'b0, tile_w_i} + CW'(2);
`else
  assign hEff = {1'b0, tile_h_i};
  assign wEff = {1'b0, tile_w_i};
`endif
  assign cEff = {1'b0, tile_c_i};

  assign tileTotal = PW'(hEff) * PW'(wEff) * PW'(cEff);
  assign dimZero   = (tile_h_i == '0) || (tile_w_i == '0) || (tile_c_i == '0);
  assign tooBig    = tileTotal > PW'(FMI_N_ELEM);

  fmi_scan_cnt #(
    .CW(CW)
  ) uScan (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (scanClear),
    .adv_i    (scanAdv),
    .rowLim_i (hLim_q),
    .colLim_i (wLim_q),
    .chLim_i  (cLim_q),
    .row_o    (scanRow),
    .col_o    (scanCol),
    .ch_o     (scanCh),
    .isPad_o  (isPad),
    .isLast_o (isLast)
  );

  // fin_q marks the cycle in which the final write is on the RAM port;
  // no further position is consumed then, and DONE follows next cycle.
  assign s_ready_o = (state_q == LD_LOAD) && !fin_q && !isPad;
  assign step      = (state_q == LD_LOAD) && !fin_q && (isPad || s_valid_i);

  always_comb begin
    state_d    = state_q;
    hLim_d     = hLim_q;
    wLim_d     = wLim_q;
    cLim_d     = cLim_q;
    addrCnt_d  = addrCnt_q;
    ramAddr_d  = ramAddr_q;
    ramData_d  = ramData_q;
    ramWrite_d = 1'b0;
    err_d      = 1'b0;
    fin_d      = fin_q;
    scanClear  = 1'b0;
    scanAdv    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (start_i) begin
          if (dimZero || tooBig) begin
            err_d = 1'b1;
          end else begin
            state_d   = LD_LOAD;
            hLim_d    = hEff;
            wLim_d    = wEff;
            cLim_d    = cEff;
            addrCnt_d = '0;
            fin_d     = 1'b0;
            scanClear = 1'b1;
          end
        end
      end
      LD_LOAD: begin
        if (fin_q) begin
          state_d = LD_DONE;
          fin_d   = 1'b0;
        end else if (step) begin
          ramWrite_d = 1'b1;
          ramAddr_d  = addrCnt_q;
          ramData_d  = isPad ? '0 : s_data_i;
          addrCnt_d  = addrCnt_q + FMI_ADDR_W'(1);
          scanAdv    = 1'b1;
          fin_d      = isLast;
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LD_IDLE;
      hLim_q     <= '0;
      wLim_q     <= '0;
      cLim_q     <= '0;
      addrCnt_q  <= '0;
      ramAddr_q  <= '0;
      ramData_q  <= '0;
      ramWrite_q <= 1'b0;
      err_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hLim_q     <= hLim_d;
      wLim_q     <= wLim_d;
      cLim_q     <= cLim_d;
      addrCnt_q  <= addrCnt_d;
      ramAddr_q  <= ramAddr_d;
      ramData_q  <= ramData_d;
      ramWrite_q <= ramWrite_d;
      err_q      <= err_d;
      fin_q      <= fin_d;
    end
  end

  assign ram_addr_o  = ramAddr_q;
  assign ram_data_o  = ramData_q;
  assign ram_write_o = ramWrite_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != LD_IDLE);
  assign done_o      = (state_q == LD_DONE);

  // Scan position is only needed inside the counter; keep it observable
  // for debug without leaving the nets dangling.
  logic scanPosUnused;
  assign scanPosUnused = ^{scanRow, scanCol, scanCh};

endmodule

// File: tb/tb_fmi_tile_loader.sv
// Self-checking bench for fmi_tile_loader.
// Builds with or without FMI_ZERO_PAD_EN; the reference model follows the
// same macro. Expected writes are derived from the tile dimensions and the
// stream beats that the loader accepted, scanned row/column/channel.

module tb_fmi_tile_loader;
  import irb_pkg::*;

  localparam int DIM_W = 6;
`ifdef FMI_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  typedef struct {
    int h;
    int w;
    int c;
    int mode;      // 100: always valid, -1: toggle 1,0,1,0, else percent
    bit inject;    // pulse a second start while loading
    bit expErr;
    int expWrites;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [DIM_W-1:0]      tileH, tileW, tileC;
  logic [PX_W-1:0]       sData;
  logic                  sValid;
  logic                  sReady;
  logic [FMI_ADDR_W-1:0] ramAddr;
  logic [PX_W-1:0]       ramData;
  logic                  ramWrite;
  logic                  busy;
  logic                  done;
  logic                  err;

  always #5 clk = ~clk;

  fmi_tile_loader #(
    .DIM_W(DIM_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .tile_h_i    (tileH),
    .tile_w_i    (tileW),
    .tile_c_i    (tileC),
    .s_data_i    (sData),
    .s_valid_i   (sValid),
    .s_ready_o   (sReady),
    .ram_addr_o  (ramAddr),
    .ram_data_o  (ramData),
    .ram_write_o (ramWrite),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wrAddr[$];
  int wrData[$];
  int wrCyc[$];
  int doneCyc[$];
  int beats[$];
  int errCnt;
  int busyCnt;
  int lastBusyCyc;
  vec_t vecs[$];

  // Output monitor: samples just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ramWrite === 1'b1) begin
      wrAddr.push_back(int'(ramAddr));
      wrData.push_back(int'(ramData));
      wrCyc.push_back(cyc);
    end
    if (done === 1'b1) doneCyc.push_back(cyc);
    if (err === 1'b1) errCnt++;
    if (busy === 1'b1) begin
      busyCnt++;
      lastBusyCyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int h, input int w, input int c,
                              input int mode, input bit inject);
    vec_t v;
    int prod;
    v.h = h; v.w = w; v.c = c; v.mode = mode; v.inject = inject;
    prod = (h + 2 * PAD) * (w + 2 * PAD) * c;
    v.expErr    = (h == 0) || (w == 0) || (c == 0) || (prod > FMI_N_ELEM);
    v.expWrites = v.expErr ? 0 : prod;
    return v;
  endfunction

  task automatic clearLog();
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    doneCyc.delete(); beats.delete();
    errCnt = 0; busyCnt = 0; lastBusyCyc = -1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearLog();
    @(negedge clk);
    start = 1'b1;
    tileH = DIM_W'(v.h); tileW = DIM_W'(v.w); tileC = DIM_W'(v.c);
    sValid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (v.inject && n == 4) begin
        start = 1'b1; tileH = 1; tileW = 1; tileC = 1;
      end else begin
        start = 1'b0;
      end
      if (v.mode == 100) sValid = 1'b1;
      else if (v.mode < 0) sValid = (n % 2 == 0);
      else sValid = ($urandom_range(99) < v.mode);
      sData = PX_W'($urandom);
      #1;
      if (sValid && sReady) beats.push_back(int'(sData));
      if (doneCyc.size() > 0 || (v.expErr && n > 4)) break;
      @(negedge clk);
    end
    start = 1'b0;
    sValid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v);
    int hp, wp, k, e;
    int expData[$];
    if (v.expErr) begin
      check("errPulse", errCnt, 1);
      check("errWrites", wrAddr.size(), 0);
      check("errBusy", busyCnt, 0);
      check("errDone", doneCyc.size(), 0);
      return;
    end
    hp = v.h + 2 * PAD;
    wp = v.w + 2 * PAD;
    k = 0;
    for (int r = 0; r < hp; r++)
      for (int cl = 0; cl < wp; cl++)
        for (int ch = 0; ch < v.c; ch++) begin
          if (PAD == 1 && (r == 0 || r == hp - 1 || cl == 0 || cl == wp - 1)) begin
            expData.push_back(0);
          end else begin
            e = (k < beats.size()) ? beats[k] : -1;
            expData.push_back(e);
            k++;
          end
        end
    check("errNone", errCnt, 0);
    check("writeCount", wrAddr.size(), v.expWrites);
    check("beatsUsed", beats.size(), v.h * v.w * v.c);
    for (int i = 0; i < wrAddr.size() && i < expData.size(); i++) begin
      check($sformatf("addr[%0d]", i), wrAddr[i], i);
      check($sformatf("data[%0d]", i), wrData[i], expData[i]);
    end
    check("doneCount", doneCyc.size(), 1);
    if (doneCyc.size() > 0 && wrCyc.size() > 0) begin
      check("doneLatency", doneCyc[0] - wrCyc[wrCyc.size() - 1], 1);
      check("busyFall", lastBusyCyc, doneCyc[0]);
      if (v.mode == 100)
        check("burstSpan", wrCyc[wrCyc.size() - 1] - wrCyc[0], v.expWrites - 1);
    end
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; tileH = '0; tileW = '0; tileC = '0;
    sValid = 1'b0; sData = '0;
    repeat (2) @(negedge clk);
    check("rstReady", int'(sReady), 0);
    check("rstAddr", int'(ramAddr), 0);
    check("rstData", int'(ramData), 0);
    check("rstWrite", int'(ramWrite), 0);
    check("rstBusy", int'(busy), 0);
    check("rstDone", int'(done), 0);
    check("rstErr", int'(err), 0);
    rst = 1'b0;

    vecs.push_back(mk(2, 2, 3, 100, 1'b0));
    vecs.push_back(mk(2, 2, 3, -1, 1'b0));
    vecs.push_back(mk(1, 1, 1, 100, 1'b0));
    vecs.push_back(mk(2, 2, 0, 100, 1'b0));
    vecs.push_back(mk(0, 3, 3, 100, 1'b0));
    vecs.push_back(mk(5, 5, 41, 100, 1'b0));
    vecs.push_back(mk(32, 32, 1, 100, 1'b0));
    vecs.push_back(mk(30, 30, 1, 100, 1'b0));
    vecs.push_back(mk(16, 16, 4, 70, 1'b0));
    vecs.push_back(mk(3, 4, 2, 60, 1'b0));
    vecs.push_back(mk(2, 2, 3, 100, 1'b1));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk($urandom_range(1, 6), $urandom_range(1, 6),
                        $urandom_range(1, 6), $urandom_range(30, 100), 1'b0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Reset in the middle of a load after five writes.
    clearLog();
    @(negedge clk);
    start = 1'b1; tileH = 2; tileW = 2; tileC = 3;
    @(negedge clk);
    start = 1'b0;
    sValid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      sData = PX_W'($urandom);
      @(negedge clk);
      if (wrAddr.size() >= 5) break;
    end
    check("midRstReach", int'(wrAddr.size() >= 5), 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("midRstReady", int'(sReady), 0);
    check("midRstAddr", int'(ramAddr), 0);
    check("midRstData", int'(ramData), 0);
    check("midRstWrite", int'(ramWrite), 0);
    check("midRstBusy", int'(busy), 0);
    check("midRstDone", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = wrAddr.size();
    repeat (6) @(negedge clk);
    check("midRstNoWrite", wrAddr.size(), n0);
    sValid = 1'b0;
    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
